// File: rtl/dsp_fir_pkg.sv
// Shared definitions for the streaming FIR engine: beat modes, FSM state
// codes, pipeline latency and the accumulator width rule.
package dsp_fir_pkg;

   // Beat modes carried on i_MODE
   localparam logic [1:0] MODE_LOAD_W = 2'b00;
   localparam logic [1:0] MODE_LOAD_D = 2'b01;
   localparam logic [1:0] MODE_RUN    = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   // Engine states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOAD_W = 3'd1;
   localparam state_t ST_LOAD_D = 3'd2;
   localparam state_t ST_RUN    = 3'd3;
   localparam state_t ST_DRAIN  = 3'd4;
   localparam state_t ST_HOLD   = 3'd5;

   // Cycles from the RUN beat to o_RESULT_VALID, on top of the tap count:
   // sample write, SRAM read, read-data register, MAC.
   localparam int FIR_PIPE_LAT = 4;

   // Product width plus guard bits so DEPTH products can never overflow
   function automatic int acc_width(input int data_width, input int guard_bits);
      return 2 * data_width + guard_bits;
   endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One multiply-accumulate lane: signed/unsigned product, accumulation and
// a finaliser that either clamps or truncates to the output width.
module fir_mac_lane
   import dsp_fir_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int GUARD_BITS   = 10,
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic                    i_CLR,
   input  logic                    i_EN,
   input  logic                    i_SIGNED,
   input  logic                    i_SAT,
   input  logic [DATA_WIDTH-1:0]   i_A,
   input  logic [DATA_WIDTH-1:0]   i_B,
   output logic [OUTPUT_WIDTH-1:0] o_RESULT,
   output logic                    o_SAT
);

   localparam int PW     = 2 * DATA_WIDTH;
   localparam int ACC_W  = acc_width(DATA_WIDTH, GUARD_BITS);
   // Extended view: one bit wider than both accumulator and output, so the
   // clamp test is the same whether the output is narrower or wider.
   localparam int EW     = (ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH;
   localparam int XW     = EW + 1;

   logic [PW-1:0]           w_prod_u;
   logic [PW-1:0]           w_prod_s;
   logic [ACC_W-1:0]        w_ext;
   logic [ACC_W-1:0]        r_acc;
   logic [XW-1:0]           w_wide;
   logic                    w_fits_s;
   logic                    w_ovf_u;

   // Operands widened before multiplying so the product is exact in PW bits
   assign w_prod_u = {{DATA_WIDTH{1'b0}}, i_A} * {{DATA_WIDTH{1'b0}}, i_B};
   assign w_prod_s = $signed({{DATA_WIDTH{i_A[DATA_WIDTH-1]}}, i_A})
                   * $signed({{DATA_WIDTH{i_B[DATA_WIDTH-1]}}, i_B});
   assign w_ext    = i_SIGNED ? {{GUARD_BITS{w_prod_s[PW-1]}}, w_prod_s}
                              : {{GUARD_BITS{1'b0}}, w_prod_u};

   // Accumulator: cleared at the start of each dot product, adds one product per enable
   always_ff @(posedge i_CLK) begin
      // NOTE: non-blocking (<=) so every register reads pre-edge values regardless of block order.
      if (i_RST)      r_acc <= '0;
      else if (i_CLR) r_acc <= '0;
      else if (i_EN)  r_acc <= r_acc + w_ext;
   end

   assign w_wide   = i_SIGNED ? XW'($signed(r_acc)) : XW'(r_acc);
   assign w_fits_s = (&w_wide[EW:OUTPUT_WIDTH-1]) | ~(|w_wide[EW:OUTPUT_WIDTH-1]);
   assign w_ovf_u  = |w_wide[EW:OUTPUT_WIDTH];

   // Finaliser: clamp to the output range when enabled, else keep the low bits
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      o_RESULT = w_wide[OUTPUT_WIDTH-1:0];
      o_SAT    = 1'b0;
      if (i_SAT) begin
         if (i_SIGNED && !w_fits_s) begin
            o_RESULT = w_wide[EW] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
            o_SAT    = 1'b1;
         end else if (!i_SIGNED && w_ovf_u) begin
            o_RESULT = '1;
            o_SAT    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dsp_fir_engine.sv
// Streaming FIR engine: loads weights and a circular sample history into
// external SRAMs, then produces one dot product per RUN sample.
module dsp_fir_engine
   import dsp_fir_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 10,
   parameter int OUTPUT_WIDTH  = 32,
   parameter int GUARD_BITS    = ADDRESS_WIDTH
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic [1:0]               i_MODE,
   input  logic                     i_VALID,
   input  logic [DATA_WIDTH-1:0]    i_DATA,
   output logic                     o_READY,
   input  logic [ADDRESS_WIDTH-1:0] i_CFG_LEN,
   input  logic                     i_CFG_SIGNED,
   input  logic                     i_CFG_SAT,
   output logic [OUTPUT_WIDTH-1:0]  o_RESULT,
   output logic                     o_RESULT_VALID,
   input  logic                     i_RESULT_READY,
   output logic                     o_SAT,
   output logic                     o_W_LOADED,
   output logic                     o_BUSY,
   output logic [ADDRESS_WIDTH-1:0] o_W_ADDR,
   output logic [ADDRESS_WIDTH-1:0] o_D_ADDR,
   output logic                     o_W_WE,
   output logic                     o_D_WE,
   output logic [DATA_WIDTH-1:0]    o_W_DIN,
   output logic [DATA_WIDTH-1:0]    o_D_DIN,
   input  logic [DATA_WIDTH-1:0]    i_W_DOUT,
   input  logic [DATA_WIDTH-1:0]    i_D_DOUT
);

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

   state_t                   r_state;
   logic [ADDRESS_WIDTH-1:0] r_ptr, r_len, r_last, r_head, r_rd_ptr;
   logic                     r_signed, r_sat, r_w_loaded, r_res_valid;
   logic                     r_w_we, r_d_we;
   logic [ADDRESS_WIDTH-1:0] r_w_addr, r_d_addr;
   logic [DATA_WIDTH-1:0]    r_w_din, r_d_din, r_w_q, r_d_q;
   // Read pipeline: address issued (0), SRAM data on bus (1), data registered (q)
   logic                     r_rd_v0, r_rd_l0, r_rd_v1, r_rd_l1, r_q_v, r_q_l;

   logic                     w_idle, w_ready, w_beat, w_start, w_run_beat;
   logic                     w_load_beat, w_to_w, w_load_done;
   logic [ADDRESS_WIDTH-1:0] w_len_now, w_last_now;

   assign w_idle      = (r_state == ST_IDLE);
   // Reserved mode is never acknowledged; a load in progress ignores i_MODE
   assign w_ready     = (w_idle && i_MODE != MODE_RSVD)
                     || r_state == ST_LOAD_W || r_state == ST_LOAD_D;
   assign w_beat      = i_VALID && w_ready;
   assign w_start     = w_beat && w_idle;
   assign w_run_beat  = w_start && i_MODE == MODE_RUN;
   assign w_load_beat = w_beat && !w_run_beat;
   assign w_to_w      = (r_state == ST_LOAD_W) || (w_idle && i_MODE == MODE_LOAD_W);
   // Config is live only on the first beat; 0 wraps to DEPTH-1 as last index
   assign w_len_now   = w_idle ? i_CFG_LEN : r_len;
   assign w_last_now  = w_len_now - ADDR_ONE;
   assign w_load_done = w_load_beat && (r_ptr == w_last_now);

   // Control FSM, SRAM port registers and read-data pipeline
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_len       <= '0;
         r_last      <= '0;
         r_head      <= '0;
         r_rd_ptr    <= '0;
         r_signed    <= 1'b0;
         r_sat       <= 1'b0;
         r_w_loaded  <= 1'b0;
         r_res_valid <= 1'b0;
         r_w_we      <= 1'b0;
         r_d_we      <= 1'b0;
         r_w_addr    <= '0;
         r_d_addr    <= '0;
         r_w_din     <= '0;
         r_d_din     <= '0;
         r_w_q       <= '0;
         r_d_q       <= '0;
         r_rd_v0     <= 1'b0;
         r_rd_l0     <= 1'b0;
         r_rd_v1     <= 1'b0;
         r_rd_l1     <= 1'b0;
         r_q_v       <= 1'b0;
         r_q_l       <= 1'b0;
      end else begin
         r_w_we  <= 1'b0;
         r_d_we  <= 1'b0;
         r_rd_v0 <= 1'b0;
         r_rd_l0 <= 1'b0;
         r_rd_v1 <= r_rd_v0;
         r_rd_l1 <= r_rd_l0;
         r_q_v   <= r_rd_v1;
         r_q_l   <= r_rd_l1;
         r_w_q   <= i_W_DOUT;
         r_d_q   <= i_D_DOUT;

         if (w_start) begin
            r_len    <= i_CFG_LEN;
            r_last   <= i_CFG_LEN - ADDR_ONE;
            r_signed <= i_CFG_SIGNED;
            r_sat    <= i_CFG_SAT;
         end

         if (w_load_beat) begin
            if (w_to_w) begin
               r_w_we   <= 1'b1;
               r_w_addr <= r_ptr;
               r_w_din  <= i_DATA;
            end else begin
               r_d_we   <= 1'b1;
               r_d_addr <= r_ptr;
               r_d_din  <= i_DATA;
            end
            if (w_load_done) begin
               r_ptr   <= '0;
               r_state <= ST_IDLE;
               if (w_to_w) r_w_loaded <= 1'b1;
               else        r_head     <= w_len_now;
            end else begin
               r_ptr   <= r_ptr + ADDR_ONE;
               r_state <= w_to_w ? ST_LOAD_W : ST_LOAD_D;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_run_beat) begin
                  r_d_we   <= 1'b1;
                  r_d_addr <= r_head;
                  r_d_din  <= i_DATA;
                  r_rd_ptr <= r_head;
                  r_head   <= r_head + ADDR_ONE;
                  r_ptr    <= '0;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Tap k pairs W[k] with D[head-k]: newest sample first
               r_w_addr <= r_ptr;
               r_d_addr <= r_rd_ptr;
               r_rd_ptr <= r_rd_ptr - ADDR_ONE;
               r_rd_v0  <= 1'b1;
               r_ptr    <= r_ptr + ADDR_ONE;
               if (r_ptr == r_last) begin
                  r_rd_l0 <= 1'b1;
                  r_ptr   <= '0;
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (r_q_v && r_q_l) begin
                  r_res_valid <= 1'b1;
                  r_state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (i_RESULT_READY) begin
                  r_res_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   fir_mac_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .GUARD_BITS   (GUARD_BITS),
      .OUTPUT_WIDTH (OUTPUT_WIDTH)
   ) u_lane (
      .i_CLK    (i_CLK),
      .i_RST    (i_RST),
      .i_CLR    (w_run_beat),
      .i_EN     (r_q_v),
      .i_SIGNED (r_signed),
      .i_SAT    (r_sat),
      .i_A      (r_w_q),
      .i_B      (r_d_q),
      .o_RESULT (o_RESULT),
      .o_SAT    (o_SAT)
   );

   assign o_READY        = w_ready;
   assign o_RESULT_VALID = r_res_valid;
   assign o_W_LOADED     = r_w_loaded;
   assign o_BUSY         = !w_idle;
   assign o_W_ADDR       = r_w_addr;
   assign o_D_ADDR       = r_d_addr;
   assign o_W_WE         = r_w_we;
   assign o_D_WE         = r_d_we;
   assign o_W_DIN        = r_w_din;
   assign o_D_DIN        = r_d_din;

endmodule
